seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector, successor to the fixed four-state Mealy detector. It detects a runtime-loadable bit pattern of 1..MAX_LEN bits on a qualified serial input. Overlap/non-overlap and Mealy/Moore output are selectable at load time, and matches are counted in a saturating counter. It sits on the serial bit stream between the deserialiser front end and the control logic that consumes detect pulses.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, match counter width
- RST_PATTERN, 8'b0000_0111, pattern loaded by reset (right-aligned)
- RST_LEN, 4, pattern length loaded by reset
- RST_OVERLAP, 0, overlap mode after reset
- RST_MEALY, 1, output mode after reset (1 = Mealy)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- In  in  1  serial data bit
- in_valid  in  1  In is sampled only when high
- cfg_load  in  1  one-cycle strobe; loads pattern, length and modes
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; cfg_pattern[len-1] is the first bit received
- cfg_len  in  LEN_W  pattern length; LEN_W = $clog2(MAX_LEN+1)
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_mealy  in  1  1 = Mealy output, 0 = Moore output
- cnt_clr  in  1  clears match_cnt
- out  out  1  detect pulse
- match_cnt  out  CNT_W  saturating count of matches
- cfg_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Registers:
  - history shift register hist[MAX_LEN-1:0]; on each accepted bit, hist <= {hist[MAX_LEN-2:0], In}
  - fill counter, 0..MAX_LEN, saturating; counts accepted bits since the last clear
  - stored pattern, length, overlap and mealy; these registers are written only by reset or an accepted load
- Accepted bit: in_valid=1 and cfg_load=0 and rst=0.
- Match (hit): the accepted bit completes the pattern. Condition: fill ≥ len-1 and {hist[len-2:0], In} == pattern[len-1:0]. For len=1 the condition reduces to In == pattern[0].
- On a hit:
  - overlap=1: fill keeps counting and saturates.
  - overlap=0: fill <= 0 and no bit of the matched pattern is reused.
- Output:
  - Mealy: out = hit, combinational, in the same cycle as the final bit.
  - Moore: out is the registered version of hit, high for exactly the next cycle.
- match_cnt increments on the edge that accepts a hitting bit, in both modes. It saturates at 2^CNT_W-1.
- cnt_clr sets match_cnt <= 0. If cnt_clr coincides with a hit, the result is 0 (clear wins).
- Load:
  - Rejected if cfg_len == 0 or cfg_len > MAX_LEN. A rejected load pulses cfg_err the next cycle; all configuration and history are unchanged.
  - An accepted load writes the configuration, clears fill and the Moore out register, and leaves match_cnt unchanged.
  - A bit presented in the load cycle is discarded and produces no hit.
- Pattern bits above len-1 are ignored in the compare.

## Timing
- Reset values:
  - out = 0, match_cnt = 0, cfg_err = 0, fill = 0, hist = 0
  - configuration = RST_* parameters
- Mealy out is forced to 0 while rst=1.
- Reset asserted mid-pattern discards the partial match; detection restarts from fill = 0 after the reset cycle.
- Latency from final bit to out: 0 cycles in Mealy mode, 1 cycle in Moore mode.
- Latency from final bit to match_cnt: 1 cycle.
- in_valid low: no shift, fill and out_q update (Moore out drops to 0), no hit. Gaps between bits are transparent to detection.
- Back-to-back hits in overlap mode with a fully periodic pattern (e.g. all ones): one hit per accepted bit. Moore out stays high continuously.

## Structure
- Package seq_det_pkg holds:
  - LEN_W as a function of MAX_LEN
  - reset-default constants
  - the mode bit meanings: OVL_ON/OVL_OFF and OUT_MEALY/OUT_MOORE
- Sub-module seq_det_sat_cnt: saturating counter with clear, parameterised by width; instantiated for match_cnt.
- Everything else lives in the top module: history, fill, compare, configuration registers and output select.

## Test plan
- Reset defaults (pattern 0111, len 4, Mealy, no overlap): bits 0,1,1,1 -> out=1 combinationally on the 4th bit; match_cnt=1 the next cycle.
- Load 1011, len 4, overlap=1, Moore; stream 1,0,1,1,0,1,1 -> out high the cycle after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> single hit after bit 4; match_cnt=1.
- Stream 0,1,(in_valid=0 for 3 cycles),1,1 with the default pattern -> hit on the final bit; load with cfg_len=0 or 9 -> cfg_err pulses once and the configuration is unchanged.
- Pattern 1, len 1, overlap, CNT_W=2; six consecutive 1s -> match_cnt saturates at 3; cnt_clr asserted together with a hit -> match_cnt=0.
- Assert rst after 3 of 4 pattern bits, then send the final bit -> no hit; a full pattern afterwards -> hit. A load in the same cycle as the final bit -> bit discarded, no hit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - len_w()           : width of a pattern-length field for a given MAX_LEN
//   - DEF_* constants   : default geometry and reset configuration
//   - ovl_mode_e        : OVL_ON / OVL_OFF overlap selection
//   - out_mode_e        : OUT_MEALY / OUT_MOORE output selection
// -----------------------------------------------------------------------------
package seq_det_pkg;

    // Length field must hold 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int       DEF_MAX_LEN     = 8;
    localparam int       DEF_CNT_W       = 8;
    localparam logic [7:0] DEF_RST_PATTERN = 8'b0000_0111;
    localparam int       DEF_RST_LEN     = 4;
    localparam logic     DEF_RST_OVERLAP = 1'b0;
    localparam logic     DEF_RST_MEALY   = 1'b1;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    typedef enum logic {
        OUT_MOORE = 1'b0,
        OUT_MEALY = 1'b1
    } out_mode_e;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// -----------------------------------------------------------------------------
// seq_det_sat_cnt
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, count <= 0
//   clr  : synchronous clear, wins over inc
//   inc  : increment request; ignored once the count is all ones
//   cnt  : registered count value
// -----------------------------------------------------------------------------
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Count register: reset/clear to zero, otherwise saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with a runtime-loadable pattern of 1..MAX_LEN bits,
// selectable overlap and Mealy/Moore output, and a saturating match counter.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   In, in_valid : serial data bit and its qualifier
//   cfg_load     : one-cycle strobe loading cfg_pattern/len/overlap/mealy
//   cfg_pattern  : right-aligned pattern, cfg_pattern[len-1] received first
//   cfg_len      : pattern length (1..MAX_LEN accepted)
//   cfg_overlap  : 1 = overlapping matches allowed
//   cfg_mealy    : 1 = Mealy output, 0 = Moore output
//   cnt_clr      : clears match_cnt (wins over a coincident hit)
//   out          : detect pulse
//   match_cnt    : saturating count of matches
//   cfg_err      : one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int                 RST_LEN     = DEF_RST_LEN,
    parameter logic               RST_OVERLAP = DEF_RST_OVERLAP,
    parameter logic               RST_MEALY   = DEF_RST_MEALY,
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               In,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_mealy,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    // The oldest history bit can never take part in a compare (the newest
    // compared bit is always In itself), so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    ovl_mode_e          overlap_r;
    out_mode_e          mealy_r;
    logic               out_q_r;
    logic               cfg_err_r;

    logic               accept_s;
    logic               load_bad_s;
    logic               fill_ok_s;
    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               hit_s;

    // Bit acceptance, load validation and the masked pattern compare.
    always_comb begin
        accept_s   = in_valid && !cfg_load && !rst;
        load_bad_s = (cfg_len == {LEN_W{1'b0}}) || (cfg_len > LEN_W'(MAX_LEN));
        window_s   = {hist_r, In};
        mask_s     = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_r);
        end
        // len_r is never 0 (rejected loads leave it untouched), so len_r-1
        // cannot wrap.
        fill_ok_s = (fill_r >= (len_r - LEN_W'(1)));
        hit_s     = accept_s && fill_ok_s &&
                    (((window_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});
    end

    // History, fill, configuration, Moore output and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r    <= {(MAX_LEN-1){1'b0}};
            fill_r    <= {LEN_W{1'b0}};
            pattern_r <= RST_PATTERN;
            len_r     <= LEN_W'(RST_LEN);
            overlap_r <= ovl_mode_e'(RST_OVERLAP);
            mealy_r   <= out_mode_e'(RST_MEALY);
            out_q_r   <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            // hit_s is 0 in a load cycle, which also clears the Moore register.
            out_q_r   <= hit_s;
            cfg_err_r <= cfg_load && load_bad_s;
            if (cfg_load) begin
                if (!load_bad_s) begin
                    pattern_r <= cfg_pattern;
                    len_r     <= cfg_len;
                    overlap_r <= ovl_mode_e'(cfg_overlap);
                    mealy_r   <= out_mode_e'(cfg_mealy);
                    fill_r    <= {LEN_W{1'b0}};
                end
            end else if (accept_s) begin
                hist_r <= window_s[MAX_LEN-2:0];
                if (hit_s && (overlap_r == OVL_OFF)) begin
                    fill_r <= {LEN_W{1'b0}};
                end else if (fill_r != LEN_W'(MAX_LEN)) begin
                    fill_r <= fill_r + LEN_W'(1);
                end
            end
        end
    end

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit_s),
        .cnt (match_cnt)
    );

    assign out     = (mealy_r == OUT_MEALY) ? (hit_s && !rst) : out_q_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic       clk = 1'b0;
    logic       rst, In, in_valid, cfg_load, cfg_overlap, cfg_mealy, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       out, cfg_err, out2, cfg_err2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .In(In), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_mealy(cfg_mealy), .cnt_clr(cnt_clr), .out(out),
        .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    // Same stimulus, narrow counter to exercise saturation.
    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .In(In), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_mealy(cfg_mealy), .cnt_clr(cnt_clr), .out(out2),
        .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    int checks = 0;
    int errors = 0;

    // Staged stimulus for the next cycle
    logic       s_rst, s_in, s_valid, s_load, s_ovl, s_mealy, s_clr;
    logic [7:0] s_pat;
    logic [3:0] s_len;

    // Reference model: queue of accepted bits since the last fill clear
    logic       m_q[$];
    logic [7:0] m_pat   = 8'b0000_0111;
    int         m_len   = 4;
    logic       m_ovl   = 1'b0;
    logic       m_mealy = 1'b1;
    logic       m_outq  = 1'b0;
    int         m_cnt   = 0;
    int         m_cnt2  = 0;

    typedef struct {
        int   cnt;
        int   cnt2;
        logic err;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic b);
        logic w;
        if (m_q.size() < m_len - 1) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            w = (k == 0) ? b : m_q[m_q.size() - k];
            if (w !== m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: drive, check out before the edge, score post-edge state.
    task automatic cyc(input string tag);
        logic accept, hit, bad, err, exp_out;
        exp_t e;
        @(negedge clk);
        rst = s_rst; In = s_in; in_valid = s_valid; cfg_load = s_load;
        cfg_pattern = s_pat; cfg_len = s_len; cfg_overlap = s_ovl;
        cfg_mealy = s_mealy; cnt_clr = s_clr;
        #1;
        accept  = s_valid && !s_load && !s_rst;
        hit     = accept && model_hit(s_in);
        exp_out = m_mealy ? hit : m_outq;
        chk({tag, ".out"}, {31'd0, out}, {31'd0, exp_out});
        chk({tag, ".out2"}, {31'd0, out2}, {31'd0, exp_out});
        bad = (s_len == 4'd0) || (s_len > 4'd8);
        if (s_rst) begin
            m_q.delete();
            m_pat = 8'b0000_0111; m_len = 4; m_ovl = 1'b0; m_mealy = 1'b1;
            m_outq = 1'b0; m_cnt = 0; m_cnt2 = 0; err = 1'b0;
        end else begin
            err    = s_load && bad;
            m_outq = hit;
            if (s_load) begin
                if (!bad) begin
                    m_pat = s_pat; m_len = int'(s_len); m_ovl = s_ovl; m_mealy = s_mealy;
                    m_q.delete();
                end
            end else if (accept) begin
                if (hit && !m_ovl) m_q.delete();
                else begin
                    m_q.push_back(s_in);
                    if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                end
            end
            if (s_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        sb_q.push_back('{m_cnt, m_cnt2, err});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".cnt"}, {24'd0, match_cnt}, e.cnt);
            chk({tag, ".cnt2"}, {30'd0, match_cnt2}, e.cnt2);
            chk({tag, ".err"}, {31'd0, cfg_err}, {31'd0, e.err});
        end
    endtask

    task automatic idle_stage();
        s_rst = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_load = 1'b0; s_clr = 1'b0;
    endtask

    task automatic bitv(input logic v, input logic b, input string tag);
        idle_stage();
        s_valid = v; s_in = b;
        cyc(tag);
    endtask

    // Send n bits MSB first from seq[n-1:0]
    task automatic send(input logic [15:0] seq, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) bitv(1'b1, seq[i], tag);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic mealy, input logic v, input logic b, input string tag);
        idle_stage();
        s_load = 1'b1; s_pat = pat; s_len = len; s_ovl = ovl; s_mealy = mealy;
        s_valid = v; s_in = b;
        cyc(tag);
    endtask

    task automatic clr_cycle(input logic v, input logic b, input string tag);
        idle_stage();
        s_clr = 1'b1; s_valid = v; s_in = b;
        cyc(tag);
    endtask

    task automatic rst_cycle(input string tag);
        idle_stage();
        s_rst = 1'b1;
        cyc(tag);
    endtask

    initial begin
        s_pat = 8'h00; s_len = 4'd0; s_ovl = 1'b0; s_mealy = 1'b0;
        idle_stage();
        rst = 1'b1; In = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = 8'h00;
        cfg_len = 4'd0; cfg_overlap = 1'b0; cfg_mealy = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", {31'd0, out}, 32'd0);
        chk("reset.cnt", {24'd0, match_cnt}, 32'd0);
        chk("reset.err", {31'd0, cfg_err}, 32'd0);

        // Reset defaults: 0111, Mealy, no overlap
        send(16'b0111, 4, "dflt");
        chk("dflt.cnt_total", {24'd0, match_cnt}, 32'd1);

        // 1011 overlap Moore: hits after bits 4 and 7
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_ovl");
        send(16'b1011011, 7, "ovl");
        bitv(1'b0, 1'b0, "ovl_tail");
        bitv(1'b0, 1'b0, "ovl_tail2");
        chk("ovl.cnt_total", {24'd0, match_cnt}, 32'd3);

        // Same stream, no overlap: single hit
        load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "ld_novl");
        send(16'b1011011, 7, "novl");
        bitv(1'b0, 1'b0, "novl_tail");
        chk("novl.cnt_total", {24'd0, match_cnt}, 32'd4);

        // Gaps are transparent
        load(8'b0000_0111, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, "ld_gap");
        send(16'b01, 2, "gap_a");
        for (int i = 0; i < 3; i++) bitv(1'b0, 1'b1, "gap_idle");
        send(16'b11, 2, "gap_b");
        chk("gap.cnt_total", {24'd0, match_cnt}, 32'd5);

        // Rejected loads: len 0 and len 9, config unchanged
        load(8'b1111_1111, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "bad0");
        chk("bad0.err_pulse", {31'd0, cfg_err}, 32'd1);
        bitv(1'b0, 1'b0, "bad0_after");
        load(8'b1111_1111, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, "bad9");
        bitv(1'b0, 1'b0, "bad9_after");
        chk("bad9.err_once", {31'd0, cfg_err}, 32'd0);
        send(16'b0111, 4, "after_bad");
        chk("after_bad.cnt_total", {24'd0, match_cnt}, 32'd6);

        // len 1, overlap, all ones: narrow counter saturates
        clr_cycle(1'b0, 1'b0, "clr");
        load(8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, "ld_len1");
        send(16'b111111, 6, "ones");
        chk("ones.cnt2_sat", {30'd0, match_cnt2}, 32'd3);
        chk("ones.cnt", {24'd0, match_cnt}, 32'd6);
        clr_cycle(1'b1, 1'b1, "clr_hit");
        chk("clr_hit.cnt", {24'd0, match_cnt}, 32'd0);

        // len 1 Moore: continuous high on back-to-back hits
        load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "ld_moore1");
        send(16'b111, 3, "moore_ones");
        chk("moore_ones.out_high", {31'd0, out}, 32'd1);
        bitv(1'b0, 1'b0, "moore_drop");

        // Reset mid-pattern discards the partial match
        rst_cycle("rst_a");
        send(16'b011, 3, "part");
        rst_cycle("rst_mid");
        bitv(1'b1, 1'b1, "after_rst");
        chk("after_rst.cnt", {24'd0, match_cnt}, 32'd0);
        send(16'b0111, 4, "full");
        chk("full.cnt", {24'd0, match_cnt}, 32'd1);

        // Load coincident with the final bit discards it
        send(16'b011, 3, "pre_ld");
        load(8'b0000_0111, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, "ld_final");
        bitv(1'b1, 1'b1, "post_ld");
        chk("ld_final.cnt", {24'd0, match_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
